// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - segment word type and active-low glyph constants for seg_mux_driver
package seg_pkg;

    typedef logic [7:0] seg_t;

    // Active-low patterns, bit 7 (dp) shown as off; [6:0] = g..a
    localparam seg_t SEG_0     = 8'hC0;
    localparam seg_t SEG_1     = 8'hF9;
    localparam seg_t SEG_2     = 8'hA4;
    localparam seg_t SEG_3     = 8'hB0;
    localparam seg_t SEG_4     = 8'h99;
    localparam seg_t SEG_5     = 8'h92;
    localparam seg_t SEG_6     = 8'h82;
    localparam seg_t SEG_7     = 8'hF8;
    localparam seg_t SEG_8     = 8'h80;
    localparam seg_t SEG_9     = 8'h90;
    localparam seg_t SEG_A     = 8'h88;
    localparam seg_t SEG_B     = 8'h83;
    localparam seg_t SEG_C     = 8'hC6;
    localparam seg_t SEG_D     = 8'hA1;
    localparam seg_t SEG_E     = 8'h86;
    localparam seg_t SEG_F     = 8'h8E;
    localparam seg_t SEG_BLANK = 8'hFF;

endpackage

// File: rtl/seg_decode.sv
// rtl/seg_decode.sv - nibble + dp to active-low segment word; SEG_HEX_EN enables A..F glyphs
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output seg_t       seg
);

    seg_t pat;

    // Glyph lookup; nibbles 10..15 stay blank unless hex glyphs are built in
    always_comb begin
        pat = SEG_BLANK;
        case (nibble)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
`ifdef SEG_HEX_EN
            4'd10:   pat = SEG_A;
            4'd11:   pat = SEG_B;
            4'd12:   pat = SEG_C;
            4'd13:   pat = SEG_D;
            4'd14:   pat = SEG_E;
            4'd15:   pat = SEG_F;
`endif
            default: pat = SEG_BLANK;
        endcase
        seg = {~dp, pat[6:0]};
    end

endmodule

// File: rtl/seg_mux_driver.sv
// rtl/seg_mux_driver.sv - multiplexed common-anode 7-seg driver with frame-boundary double buffering (SEG_HEX_EN)
module seg_mux_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] act_digits_q, act_digits_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [4*NUM_DIGITS-1:0] pend_digits_q, pend_digits_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                    pend_v_q, pend_v_d;
    seg_t                    seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_done_q, frame_done_d;

    logic term;
    logic wrap;
    seg_t dec_seg;

    seg_decode u_decode (
        .nibble (act_digits_q[{idx_q, 2'b00} +: 4]),
        .dp     (act_dp_q[idx_q]),
        .seg    (dec_seg)
    );

    // Scan position and the pending/active double buffer
    always_comb begin
        term          = (cnt_q == CNT_LAST);
        wrap          = term && (idx_q == IDX_LAST);
        cnt_d         = term ? '0 : cnt_q + 1'b1;
        idx_d         = idx_q;
        act_digits_d  = act_digits_q;
        act_dp_d      = act_dp_q;
        pend_digits_d = pend_digits_q;
        pend_dp_d     = pend_dp_q;
        pend_v_d      = pend_v_q;
        if (term) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        if (wrap) begin
            // A load landing on the wrap itself beats anything already pending
            if (load) begin
                act_digits_d = digits;
                act_dp_d     = dp;
            end else if (pend_v_q) begin
                act_digits_d = pend_digits_q;
                act_dp_d     = pend_dp_q;
            end
            pend_v_d = 1'b0;
        end else if (load) begin
            pend_digits_d = digits;
            pend_dp_d     = dp;
            pend_v_d      = 1'b1;
        end
    end

    // Next output word: blank at slot start and for disabled digits
    always_comb begin
        an_d         = '1;
        seg_d        = SEG_BLANK;
        frame_done_d = wrap;
        if (cnt_q >= CNT_BLANK && digit_en[idx_q]) begin
            an_d[idx_q] = 1'b0;
            seg_d       = dec_seg;
        end
    end

    // State and registered outputs, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            act_digits_q  <= '0;
            act_dp_q      <= '0;
            pend_digits_q <= '0;
            pend_dp_q     <= '0;
            pend_v_q      <= 1'b0;
            seg_q         <= SEG_BLANK;
            an_q          <= '1;
            frame_done_q  <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            act_digits_q  <= act_digits_d;
            act_dp_q      <= act_dp_d;
            pend_digits_q <= pend_digits_d;
            pend_dp_q     <= pend_dp_d;
            pend_v_q      <= pend_v_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_mux_driver.sv
// tb/tb_seg_mux_driver.sv - frame-level model plus directed checks for seg_mux_driver
module tb_seg_mux_driver;

    localparam int ND  = 4;
    localparam int RD  = 4;
    localparam int BC  = 1;
    localparam int FRM = ND * RD;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [15:0]   digits = '0;
    logic [3:0]    dp = '0;
    logic [3:0]    digit_en = 4'hF;
    logic          load = 1'b0;
    logic [7:0]    seg;
    logic [3:0]    an;
    logic          frame_done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [15:0] shown_d = '0, pend_d = '0;
    logic [3:0]  shown_dp = '0, pend_dp = '0;
    logic        pv = 1'b0;
    logic [7:0]  exp_seg = 8'hFF;
    logic [3:0]  exp_an = 4'hF;
    logic        exp_fd = 1'b0;

    seg_mux_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .rst_n(rst_n), .digits(digits), .dp(dp), .digit_en(digit_en),
        .load(load), .seg(seg), .an(an), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] glyph(input logic [3:0] n);
        case (n)
            4'd0: return 8'hC0;  4'd1: return 8'hF9;  4'd2: return 8'hA4;  4'd3: return 8'hB0;
            4'd4: return 8'h99;  4'd5: return 8'h92;  4'd6: return 8'h82;  4'd7: return 8'hF8;
            4'd8: return 8'h80;  4'd9: return 8'h90;
`ifdef SEG_HEX_EN
            4'd10: return 8'h88; 4'd11: return 8'h83; 4'd12: return 8'hC6;
            4'd13: return 8'hA1; 4'd14: return 8'h86; 4'd15: return 8'h8E;
`endif
            default: return 8'hFF;
        endcase
    endfunction

    // Model: cycle p (since release) is slot p/RD mod ND, position p mod RD; frames swap data at p mod FRM == FRM-1
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0; shown_d = '0; shown_dp = '0; pend_d = '0; pend_dp = '0; pv = 1'b0;
            exp_seg = 8'hFF; exp_an = 4'hF; exp_fd = 1'b0;
        end else begin
            int p, k, c;
            logic [7:0] g;
            p = cyc; k = (p / RD) % ND; c = p % RD;
            exp_fd = (p % FRM) == FRM - 1;
            if (c < BC || !digit_en[k]) begin
                exp_an = 4'hF; exp_seg = 8'hFF;
            end else begin
                g = glyph(shown_d[4*k +: 4]);
                exp_an = ~(4'b0001 << k);
                exp_seg = {~shown_dp[k], g[6:0]};
            end
            if (exp_fd) begin
                if (load) begin shown_d = digits; shown_dp = dp; end
                else if (pv) begin shown_d = pend_d; shown_dp = pend_dp; end
                pv = 1'b0;
            end else if (load) begin
                pend_d = digits; pend_dp = dp; pv = 1'b1;
            end
            cyc = cyc + 1;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        total++;
        if (seg !== exp_seg || an !== exp_an || frame_done !== exp_fd) begin
            bad++;
            $display("FAIL model cyc=%0d seg=%h/%h an=%b/%b fd=%b/%b (actual/required)",
                     cyc, seg, exp_seg, an, exp_an, frame_done, exp_fd);
        end
    end

    task automatic lit(input string name, input logic [3:0] ea, input logic [7:0] es);
        total++;
        if (an !== ea || seg !== es) begin
            bad++;
            $display("FAIL %s an=%b required %b, seg=%h required %h", name, an, ea, seg, es);
        end
    endtask

    task automatic wait_cyc(input int p);
        int n = 0;
        while (cyc != p && n < 3000) begin @(negedge clk); n++; end
        if (cyc != p) begin
            total++; bad++;
            $display("FAIL wait_cyc reached %0d required %0d", cyc, p);
        end
    endtask

    task automatic chk_at(input int p, input string name, input logic [3:0] ea, input logic [7:0] es);
        wait_cyc(p + 1);
        lit(name, ea, es);
    endtask

    task automatic do_load(input int p, input logic [15:0] d, input logic [3:0] dv);
        wait_cyc(p);
        digits = d; dp = dv; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        int fd_at;
        #1 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            lit("reset_hold", 4'hF, 8'hFF);
        end
        rst_n = 1'b1;

        fd_at = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (frame_done) begin fd_at = i; break; end
        end
        total++;
        if (fd_at != 16) begin
            bad++;
            $display("FAIL first_frame_done at %0d required 16", fd_at);
        end

        do_load(21, 16'h1234, 4'b0010);
        chk_at(29, "pre_wrap", 4'b0111, 8'hC0);
        chk_at(32, "slot_blank", 4'hF, 8'hFF);
        chk_at(34, "basic_d0", 4'b1110, 8'h99);
        chk_at(38, "basic_d1", 4'b1101, 8'h30);
        chk_at(42, "basic_d2", 4'b1011, 8'hA4);
        chk_at(46, "basic_d3", 4'b0111, 8'hF9);

        do_load(50, 16'h1111, 4'b0000);
        do_load(55, 16'h9999, 4'b0000);
        chk_at(66, "last_load_wins", 4'b1110, 8'h90);
        do_load(79, 16'h5555, 4'b0000);
        chk_at(82, "load_on_wrap", 4'b1110, 8'h92);

        wait_cyc(95);
        digit_en = 4'b1011;
        chk_at(98, "en_d0", 4'b1110, 8'h92);
        chk_at(106, "en_d2_off", 4'hF, 8'hFF);
        chk_at(110, "en_d3", 4'b0111, 8'h92);
        wait_cyc(112);
        digit_en = 4'hF;

        do_load(113, 16'h000A, 4'b0000);
`ifdef SEG_HEX_EN
        chk_at(130, "hex_a", 4'b1110, 8'h88);
`else
        chk_at(130, "hex_a", 4'b1110, 8'hFF);
`endif

        do_load(140, 16'h8888, 4'b0001);
        chk_at(146, "dp_lit", 4'b1110, 8'h00);
        do_load(150, 16'h7777, 4'b0000);
        wait_cyc(152);
        #2 rst_n = 1'b0;
        #1;
        lit("async_reset", 4'hF, 8'hFF);
        total++;
        if (frame_done !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_fd frame_done=%b required 0", frame_done);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk_at(2, "post_reset_d0", 4'b1110, 8'hC0);
        chk_at(18, "no_stale_data", 4'b1110, 8'hC0);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
